// File: rtl/sumdiff_mult_pipe_pkg.sv
// Shared constants and helpers for the (A+B)*(A-B) pipeline.
package sumdiff_pkg;

  localparam int unsigned SDM_STAGES = 3;

  // Exact signed width of A^2-B^2 for W-bit operands in either mode.
  function automatic int unsigned ow_of(input int unsigned w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/sumdiff_mult_pipe_if.sv
// Operand/result handshake bundle for sumdiff_mult_pipe.
interface sumdiff_mult_pipe_if
  import sumdiff_pkg::*;
#(
  parameter int unsigned W = 4
);
  localparam int unsigned OW = ow_of(W);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_signed;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_c;
  logic          busy;

  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, out_c, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, out_c, busy
  );
endinterface

// File: rtl/sdm_stage_reg.sv
// Generic valid/ready register slice; loads whenever empty or draining downstream.
module sdm_stage_reg #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [DW-1:0] up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [DW-1:0] dn_data
);

  logic          valid_q;
  logic [DW-1:0] data_q;

  // Empty slices always accept, so bubbles collapse under a stalled output.
  assign up_ready = !valid_q || dn_ready;
  assign dn_valid = valid_q;
  assign dn_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (up_ready) begin
      valid_q <= up_valid;
      if (up_valid) begin
        data_q <= up_data;
      end
    end
  end

endmodule

// File: rtl/sumdiff_mult_pipe.sv
// Three-stage pipelined C = (A+B)*(A-B) with per-transaction signed/unsigned operands.
module sumdiff_mult_pipe
  import sumdiff_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input logic               clk,
  input logic               rst_n,
  sumdiff_mult_pipe_if.slave bus
);

  localparam int unsigned OW = ow_of(W);
  localparam int unsigned EW = W + 2;
  localparam int unsigned PW = 2 * EW;

  // Keeps in_ready low during reset and asserts it one edge after release.
  logic ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  logic signed [EW-1:0] a_ext, b_ext, sum, dif;

  always_comb begin
    a_ext = bus.in_signed ? {{2{bus.in_a[W-1]}}, bus.in_a} : {2'b00, bus.in_a};
    b_ext = bus.in_signed ? {{2{bus.in_b[W-1]}}, bus.in_b} : {2'b00, bus.in_b};
    sum   = a_ext + b_ext;
    dif   = a_ext - b_ext;
  end

  logic              s1_up_valid, s1_up_ready, s1_dn_valid, s1_dn_ready;
  logic [2*EW-1:0]   s1_dn_data;
  logic              s2_dn_valid, s2_dn_ready;
  logic [PW-1:0]     s2_dn_data;
  logic              s3_dn_valid;
  logic [OW-1:0]     s3_dn_data;

  assign s1_up_valid  = bus.in_valid && ready_q;
  assign bus.in_ready = s1_up_ready && ready_q;

  sdm_stage_reg #(.DW(2 * EW)) u_stage1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (s1_up_valid),
    .up_ready (s1_up_ready),
    .up_data  ({sum, dif}),
    .dn_valid (s1_dn_valid),
    .dn_ready (s1_dn_ready),
    .dn_data  (s1_dn_data)
  );

  logic signed [EW-1:0] s_q, d_q;
  logic signed [PW-1:0] prod;

  always_comb begin
    s_q  = s1_dn_data[2*EW-1:EW];
    d_q  = s1_dn_data[EW-1:0];
    prod = PW'(s_q) * PW'(d_q);
  end

  sdm_stage_reg #(.DW(PW)) u_stage2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (s1_dn_valid),
    .up_ready (s1_dn_ready),
    .up_data  (prod),
    .dn_valid (s2_dn_valid),
    .dn_ready (s2_dn_ready),
    .dn_data  (s2_dn_data)
  );

  // Upper product bits are pure sign extension of the exact OW-bit result.
  logic unused_p_hi;
  assign unused_p_hi = ^s2_dn_data[PW-1:OW];

  sdm_stage_reg #(.DW(OW)) u_stage3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (s2_dn_valid),
    .up_ready (s2_dn_ready),
    .up_data  (s2_dn_data[OW-1:0]),
    .dn_valid (s3_dn_valid),
    .dn_ready (bus.out_ready),
    .dn_data  (s3_dn_data)
  );

  assign bus.out_valid = s3_dn_valid;
  assign bus.out_c     = s3_dn_data;
  assign bus.busy      = s1_dn_valid || s2_dn_valid || s3_dn_valid;

endmodule

// File: tb/tb_sumdiff_mult_pipe.sv
// Randomised and directed self-checking bench for sumdiff_mult_pipe (W=4).
module tb_sumdiff_mult_pipe;
  import sumdiff_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned OW = ow_of(W);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sumdiff_mult_pipe_if #(.W(W)) bus ();

  sumdiff_mult_pipe #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int acc_q[$];
  int cyc      = 0;
  int n_acc    = 0;
  int n_emit   = 0;
  bit dir_mode = 1'b1;
  bit lat_chk  = 1'b1;
  int cur_exp  = 0;
  bit done5    = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference: interpret operands per mode, then A^2 - B^2 in plain integers.
  function automatic int model(input int a, input int b, input bit sgn);
    int av = a;
    int bv = b;
    if (sgn && a >= (1 << (W - 1))) av = a - (1 << W);
    if (sgn && b >= (1 << (W - 1))) bv = b - (1 << W);
    return av * av - bv * bv;
  endfunction

  // Observe both channels at the negative edge, where everything is settled.
  initial begin
    bit prev_stall = 1'b0;
    int prev_c     = 0;
    int got;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        got = $signed(bus.out_c);
        if (prev_stall) begin
          check("stall_hold_valid", int'(bus.out_valid), 1);
          check("stall_hold_c", got, prev_c);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("out_extra", int'(bus.out_valid), 0);
          end else begin
            int e, t;
            e = exp_q.pop_front();
            t = acc_q.pop_front();
            check("out_c", got, e);
            if (lat_chk) check("latency", cyc - t, SDM_STAGES);
            n_emit++;
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(dir_mode ? cur_exp :
                          model(int'(bus.in_a), int'(bus.in_b), bus.in_signed));
          acc_q.push_back(cyc);
          n_acc++;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_c     = got;
        cyc++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input int a, input int b, input bit sgn, input int e);
    bit done = 1'b0;
    int k = 0;
    bus.in_a      = a[W-1:0];
    bus.in_b      = b[W-1:0];
    bus.in_signed = sgn;
    cur_exp       = e;
    bus.in_valid  = 1'b1;
    while (!done && k < 200) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      k++;
    end
    if (!done) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    bus.out_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.busy) && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", int'(bus.busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int acc0, emit0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b1;

    #12;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_out_c", int'(bus.out_c), 0);
    check("rst_in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", int'(bus.in_ready), 0);
    idle(1);
    check("in_ready_after_edge", int'(bus.in_ready), 1);

    // Unsigned basics, then unsigned extremes
    send(1, 2, 1'b0, -3);
    send(3, 5, 1'b0, -16);
    send(6, 2, 1'b0, 32);
    drain();
    send(15, 0, 1'b0, 225);
    send(0, 15, 1'b0, -225);
    send(15, 15, 1'b0, 0);
    drain();

    // Signed extremes and mixed-mode back-to-back
    send(8, 0, 1'b1, 64);
    send(0, 8, 1'b1, -64);
    send(8, 7, 1'b1, 15);
    send(7, 8, 1'b1, -15);
    send(8, 0, 1'b0, 64);
    send(15, 0, 1'b1, 1);
    drain();

    // Backpressure: six pairs against a five-cycle output stall
    lat_chk       = 1'b0;
    acc0          = n_acc;
    emit0         = n_emit;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(i + 2, i, 1'b0, 4 * i + 4);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        check("bp_in_ready", int'(bus.in_ready), 0);
        check("bp_accepts", n_acc - acc0, 3);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_emitted", n_emit - emit0, 6);

    // Random traffic against the reference model
    dir_mode = 1'b0;
    emit0    = n_emit;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
          send(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 0);
        end
        done5 = 1'b1;
      end
      begin
        while (!done5) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    drain();
    check("rand_emitted", n_emit - emit0, 1000);

    // Reset with two results in flight
    dir_mode = 1'b1;
    lat_chk  = 1'b1;
    send(3, 1, 1'b0, 8);
    send(2, 1, 1'b0, 3);
    check("pre_rst_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_in_ready", int'(bus.in_ready), 0);
    exp_q.delete();
    acc_q.delete();
    idle(1);
    rst_n = 1'b1;
    idle(4);
    check("post_rst_out_valid", int'(bus.out_valid), 0);
    emit0 = n_emit;
    send(5, 3, 1'b0, 16);
    send(9, 14, 1'b1, 45);
    drain();
    check("post_rst_emitted", n_emit - emit0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
